// File: rtl/mult_arb.sv
// Four-requester arbiter in front of a shared multi-cycle multiplier with a busy/done handshake and WAIT timeout.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority with req[0] highest.
module mult_arb #(
    parameter int W          = 8,
    parameter int START_HOLD = 2,
    parameter int TMO_CYC    = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [4*W-1:0]   a_in,
    input  logic [4*W-1:0]   b_in,
    output logic [3:0]       gnt,
    output logic [3:0]       done,
    output logic [2*W-1:0]   result,
    output logic             err,
    output logic [W-1:0]     m_a,
    output logic [W-1:0]     m_b,
    output logic             m_start,
    input  logic             m_busy,
    input  logic [2*W-1:0]   m_ab
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [3:0]      done_q, done_d;
    logic [2*W-1:0]  result_q, result_d;
    logic            err_q, err_d;
    logic [W-1:0]    m_a_q, m_a_d;
    logic [W-1:0]    m_b_q, m_b_d;
    logic            m_start_q, m_start_d;
    logic [3:0]      hold_cnt_q, hold_cnt_d;
    logic [7:0]      tmo_cnt_q, tmo_cnt_d;
    logic            seen_busy_q, seen_busy_d;
    logic [1:0]      idx_q, idx_d;

    logic [W-1:0]    a_slice [4];
    logic [W-1:0]    b_slice [4];
    logic [1:0]      base;
    logic [3:0]      req_rot;
    logic [1:0]      sel_off;
    logic [1:0]      sel_idx;

`ifdef MULT_ARB_RR_EN
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    assign base = rr_ptr_q;
`else
    assign base = 2'd0;
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_slice
        assign a_slice[gi] = a_in[gi*W +: W];
        assign b_slice[gi] = b_in[gi*W +: W];
        // Rotate so that position 0 is the requester the search starts from.
        assign req_rot[gi] = req[base + 2'(gi)];
    end

    always_comb begin
        sel_off = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_off = 2'(i);
            end
        end
    end

    assign sel_idx = base + sel_off;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = done_q;
        result_d    = result_q;
        err_d       = err_q;
        m_a_d       = m_a_q;
        m_b_d       = m_b_q;
        m_start_d   = m_start_q;
        hold_cnt_d  = hold_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        seen_busy_d = seen_busy_q;
        idx_d       = idx_q;
`ifdef MULT_ARB_RR_EN
        rr_ptr_d    = rr_ptr_q;
`endif

        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d      = sel_idx;
                    gnt_d      = 4'b0001 << sel_idx;
                    m_a_d      = a_slice[sel_idx];
                    m_b_d      = b_slice[sel_idx];
                    m_start_d  = 1'b1;
                    hold_cnt_d = 4'(START_HOLD);
                    state_d    = START;
                end
            end
            START: begin
                seen_busy_d = seen_busy_q | m_busy;
                if (hold_cnt_q == 4'd1) begin
                    // Fresh busy tracking for WAIT; busy seen on this very cycle still counts.
                    m_start_d   = 1'b0;
                    hold_cnt_d  = 4'd0;
                    seen_busy_d = m_busy;
                    tmo_cnt_d   = 8'd0;
                    state_d     = WAIT;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            WAIT: begin
                seen_busy_d = seen_busy_q | m_busy;
                if (seen_busy_q && !m_busy) begin
                    result_d = m_ab;
                    err_d    = 1'b0;
                    done_d   = 4'b0001 << idx_q;
                    state_d  = DONE;
                end else if (tmo_cnt_q == 8'(TMO_CYC - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = 4'b0001 << idx_q;
                    state_d  = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            DONE: begin
                gnt_d   = 4'd0;
                done_d  = 4'd0;
                err_d   = 1'b0;
                state_d = IDLE;
`ifdef MULT_ARB_RR_EN
                rr_ptr_d = idx_q + 2'd1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= 4'd0;
            done_q      <= 4'd0;
            result_q    <= '0;
            err_q       <= 1'b0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            m_start_q   <= 1'b0;
            hold_cnt_q  <= 4'd0;
            tmo_cnt_q   <= 8'd0;
            seen_busy_q <= 1'b0;
            idx_q       <= 2'd0;
`ifdef MULT_ARB_RR_EN
            rr_ptr_q    <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            err_q       <= err_d;
            m_a_q       <= m_a_d;
            m_b_q       <= m_b_d;
            m_start_q   <= m_start_d;
            hold_cnt_q  <= hold_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            seen_busy_q <= seen_busy_d;
            idx_q       <= idx_d;
`ifdef MULT_ARB_RR_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign result  = result_q;
    assign err     = err_q;
    assign m_a     = m_a_q;
    assign m_b     = m_b_q;
    assign m_start = m_start_q;

endmodule

// File: tb/tb_mult_arb.sv
// Randomized bench for mult_arb: a transaction-level model predicts grantee, product, err and latency.
module tb_mult_arb;
    localparam int W   = 8;
    localparam int SH  = 2;
    localparam int TMO = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [4*W-1:0]   a_in, b_in;
    logic [3:0]       gnt, done;
    logic [2*W-1:0]   result;
    logic             err;
    logic [W-1:0]     m_a, m_b;
    logic             m_start;
    logic             m_busy;
    logic [2*W-1:0]   m_ab;

    mult_arb #(.W(W), .START_HOLD(SH), .TMO_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .result(result), .err(err),
        .m_a(m_a), .m_b(m_b), .m_start(m_start), .m_busy(m_busy), .m_ab(m_ab)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Multiplier model: goes busy for busy_len_cfg cycles once m_start falls; 0 means it never answers.
    int   busy_len_cfg = 4;
    int   busy_cnt     = 0;
    logic prev_start   = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            busy_cnt   = 0;
            m_busy     = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (prev_start && !m_start) begin
                if (busy_len_cfg > 0) begin
                    busy_cnt = busy_len_cfg;
                    m_busy   = 1'b1;
                    m_ab     = 16'(m_a) * 16'(m_b);
                end else begin
                    m_ab = 16'($urandom);
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) m_busy = 1'b0;
            end
            prev_start = m_start;
        end
    end

    int ptr_model = 0;

    function automatic int pick(input logic [3:0] r, input int p);
        int idx;
        for (int off = 0; off < 4; off++) begin
            idx = (p + off) % 4;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // Called on a negedge with the DUT idle; returns on the negedge after DONE.
    task automatic run_txn(input logic [3:0] r, input logic [4*W-1:0] av, input logic [4*W-1:0] bv,
                           input int blen, input bit change_ops, input string tag);
        int k, lat, starts, exp_lat, p;
        logic [3:0] oh;
        logic [2*W-1:0] exp_res;
`ifdef MULT_ARB_RR_EN
        p = ptr_model;
`else
        p = 0;
`endif
        busy_len_cfg = blen;
        req  = r;
        a_in = av;
        b_in = bv;
        k  = pick(r, p);
        oh = 4'(1 << k);
        exp_res = (blen > 0) ? 16'(av[k*W +: W]) * 16'(bv[k*W +: W]) : '0;
        exp_lat = (blen > 0) ? SH + blen + 1 : SH + TMO;
        @(negedge clk);
        check_val({tag, "_gnt"}, 64'(gnt), 64'(oh));
        check_val({tag, "_m_a"}, 64'(m_a), 64'(av[k*W +: W]));
        check_val({tag, "_m_b"}, 64'(m_b), 64'(bv[k*W +: W]));
        if (change_ops) begin
            a_in = 32'($urandom);
            b_in = 32'($urandom);
            req  = r & ~oh;
        end
        starts = 1;
        lat    = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (m_start) starts++;
            if (done != 4'd0) break;
        end
        check_val({tag, "_lat"},    64'(lat),    64'(exp_lat));
        check_val({tag, "_starts"}, 64'(starts), 64'(SH));
        check_val({tag, "_done"},   64'(done),   64'(oh));
        check_val({tag, "_res"},    64'(result), 64'(exp_res));
        check_val({tag, "_err"},    64'(err),    64'(blen == 0));
        check_val({tag, "_gnt_dn"}, 64'(gnt),    64'(oh));
        @(negedge clk);
        check_val({tag, "_done_clr"}, 64'(done),   64'd0);
        check_val({tag, "_gnt_clr"},  64'(gnt),    64'd0);
        check_val({tag, "_err_clr"},  64'(err),    64'd0);
        check_val({tag, "_res_hold"}, 64'(result), 64'(exp_res));
        $display("txn %s: req=%b k=%0d blen=%0d result=%0d err=%0b lat=%0d", tag, r, k, blen, result, err, lat);
        ptr_model = (k + 1) % 4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4*W-1:0] av, bv;
        logic [3:0] r;
        int blen;
        reset = 1'b1;
        req   = 4'd0;
        a_in  = '0;
        b_in  = '0;
        m_busy = 1'b0;
        m_ab   = '0;
        repeat (2) @(negedge clk);
        check_val("rst_gnt",     64'(gnt),     64'd0);
        check_val("rst_done",    64'(done),    64'd0);
        check_val("rst_err",     64'(err),     64'd0);
        check_val("rst_result",  64'(result),  64'd0);
        check_val("rst_m_start", 64'(m_start), 64'd0);
        check_val("rst_m_a",     64'(m_a),     64'd0);
        check_val("rst_m_b",     64'(m_b),     64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Contention with all requests held.
        for (int i = 0; i < 4; i++) begin
            av[i*W +: W] = W'(i + 2);
            bv[i*W +: W] = W'(7);
        end
        for (int n = 0; n < 5; n++) begin
            run_txn(4'b1111, av, bv, int'($urandom_range(1, 6)), 1'b0, $sformatf("cont%0d", n));
        end

        av = 32'($urandom); bv = 32'($urandom);
        av[W-1:0] = W'(3); bv[W-1:0] = W'(17);
        run_txn(4'b0001, av, bv, 4, 1'b0, "single");

        run_txn(4'b0100, 32'($urandom), 32'($urandom), 0, 1'b0, "tmo");
        run_txn(4'b0100, 32'($urandom), 32'($urandom), 3, 1'b0, "post_tmo");

        av = 32'($urandom); bv = 32'($urandom);
        av[W-1:0] = W'(5); bv[W-1:0] = W'(5);
        run_txn(4'b0001, av, bv, 2, 1'b1, "opchg");

        // Reset while the multiplier is busy.
        busy_len_cfg = 10;
        req = 4'b0010;
        a_in = '0; b_in = '0;
        a_in[W +: W] = W'(7); b_in[W +: W] = W'(7);
        @(negedge clk);
        check_val("mrst_gnt", 64'(gnt), 64'b0010);
        repeat (SH + 3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("mrst_gnt0",    64'(gnt),     64'd0);
        check_val("mrst_done0",   64'(done),    64'd0);
        check_val("mrst_res0",    64'(result),  64'd0);
        check_val("mrst_start0",  64'(m_start), 64'd0);
        check_val("mrst_ma0",     64'(m_a),     64'd0);
        @(negedge clk);
        check_val("mrst_done_hold", 64'(done), 64'd0);
        reset = 1'b0;
        ptr_model = 0;
        av = '0; bv = '0;
        av[W +: W] = W'(7); bv[W +: W] = W'(7);
        run_txn(4'b0010, av, bv, 4, 1'b0, "after_rst");

        for (int n = 0; n < 25; n++) begin
            r = 4'($urandom_range(1, 15));
            blen = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            run_txn(r, 32'($urandom), 32'($urandom), blen, 1'($urandom), $sformatf("rnd%0d", n));
        end

        req = 4'd0;
        repeat (3) @(negedge clk);
        check_val("final_idle_gnt", 64'(gnt), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits; the product width is 2*W.
REQ-002 The block SHALL have parameter START_HOLD, default 2, giving the number of cycles m_start is held high (legal range 1..15).
REQ-003 The block SHALL have parameter TMO_CYC, default 64, giving the maximum number of WAIT cycles before a timeout (legal range 2..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req, input, 4 bits: level request per requester i.
REQ-007 The block SHALL have port a_in, input, 4*W bits: requester i operand A in bits [i*W +: W].
REQ-008 The block SHALL have port b_in, input, 4*W bits: requester i operand B in bits [i*W +: W].
REQ-009 The block SHALL have port gnt, output, 4 bits: one-hot grant to the requester being served.
REQ-010 The block SHALL have port done, output, 4 bits: one-cycle completion pulse to the grantee.
REQ-011 The block SHALL have port result, output, 2*W bits: the product, valid while any done bit is high.
REQ-012 The block SHALL have port err, output, 1 bit: timeout flag, valid with done.
REQ-013 The block SHALL have ports m_a and m_b, output, W bits each: multiplier operands.
REQ-014 The block SHALL have port m_start, output, 1 bit: multiplier start.
REQ-015 The block SHALL have ports m_busy (input, 1 bit) and m_ab (input, 2*W bits): multiplier busy flag and product.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, START, WAIT and DONE.
REQ-017 In IDLE with req!=0, the next edge SHALL select one requester k, set gnt to one-hot k, latch m_a/m_b from slice k, set m_start=1, load the hold counter with START_HOLD and enter START.
REQ-018 START SHALL keep m_start high for exactly START_HOLD cycles, then drive m_start low, clear the seen_busy flag and the timeout counter, and enter WAIT.
REQ-019 seen_busy SHALL be set on any cycle in START or WAIT where m_busy=1.
REQ-020 WAIT SHALL exit when seen_busy=1 and m_busy=0: capture m_ab into result, set err=0, set done[k]=1 and enter DONE.
REQ-021 If the WAIT counter reaches TMO_CYC before that exit condition, WAIT SHALL exit with result=0, err=1 and done[k]=1, and enter DONE.
REQ-022 DONE SHALL last one cycle, then clear gnt, done and err, and return to IDLE; result SHALL hold its value until the next capture.
REQ-023 Operands SHALL be latched only at grant; changes on a_in, b_in or req[k] after grant SHALL NOT affect the operation in flight, and done[k] SHALL still pulse.
REQ-024 A requester that keeps req high after its done pulse SHALL be treated as a new request in IDLE.
REQ-025 Minimum request-to-done latency SHALL be START_HOLD+2 cycles; gnt SHALL never be high in IDLE, and at most one bit of gnt or done SHALL be high at any time.

Reset
REQ-026 Asserting reset SHALL immediately force: state=IDLE, gnt=0, done=0, err=0, result=0, m_start=0, m_a=0, m_b=0, all counters and seen_busy cleared, and the round-robin pointer set to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first grant after release SHALL be no earlier than the first edge after reset falls.

Configuration
REQ-028 With MULT_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the pointer p, and on leaving DONE p becomes (k+1) mod 4.
REQ-029 With MULT_ARB_RR_EN undefined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest) and no pointer register shall exist.

Verification
REQ-030 Single request: req=0001, a=3, b=17, model busy 4 cycles -> gnt=0001, m_start high 2 cycles, done=0001 with result=51, err=0.
REQ-031 Contention (RR_EN): req=1111 held, a_i=i+2, b_i=7 -> done order 0,1,2,3,0 with results 14,21,28,35,14; in fixed-priority build, requester 0 is served every time.
REQ-032 Timeout: model never asserts busy, req=0100 -> after START_HOLD+TMO_CYC cycles done=0100, err=1, result=0; the next request completes normally.
REQ-033 Mid-op reset: req=0010, a=7, b=7, reset pulsed during WAIT -> all outputs 0 immediately, no done pulse; re-request yields result=49.
REQ-034 Operand change after grant: req=0001 a=5 b=5, a_in changed to 9 in cycle 2 -> result=25.
